// File: rtl/window_dispatcher.sv
// Raster sweep sequencer: issues one start per (x, y) window origin, waits for the
// accelerator's done, and aborts the sweep through a watchdog if done never arrives.
module window_dispatcher #(
  parameter logic [8:0]  XLAST = 9'd63,
  parameter logic [8:0]  YLAST = 9'd63,
  parameter logic [8:0]  STEP  = 9'd1,
  parameter logic [19:0] TMO   = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        done,
  output logic        start,
  output logic [8:0]  iX,
  output logic [8:0]  iY,
  output logic        busy,
  output logic        all_done,
  output logic        err,
  output logic [15:0] job_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [19:0] wd_q, wd_d;
  logic [15:0] job_cnt_q, job_cnt_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        all_done_q, all_done_d;
  logic [9:0]  x_sum, y_sum;
  logic        x_over, y_over;

  // Sums are 10 bits wide so an origin near 511 cannot wrap before the compare.
  assign x_sum  = {1'b0, x_q} + {1'b0, STEP};
  assign y_sum  = {1'b0, y_q} + {1'b0, STEP};
  assign x_over = x_sum > {1'b0, XLAST};
  assign y_over = y_sum > {1'b0, YLAST};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    wd_d       = wd_q;
    job_cnt_d  = job_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d   = S_ISSUE;
          x_d       = 9'd0;
          y_d       = 9'd0;
          job_cnt_d = 16'd0;
          err_d     = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wd_d    = 20'd0;
      end
      S_WAIT: begin
        wd_d = wd_q + 20'd1;
        // A done arriving on the timeout cycle still counts as completion.
        if (done) begin
          state_d = S_ADVANCE;
        end else if (wd_q == TMO - 20'd1) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (job_cnt_q != 16'hFFFF) job_cnt_d = job_cnt_q + 16'd1;
        if (x_over && y_over) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ISSUE;
          if (x_over) begin
            x_d = 9'd0;
            y_d = y_sum[8:0];
          end else begin
            x_d = x_sum[8:0];
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    start_d    = (state_d == S_ISSUE);
    busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_ADVANCE);
    all_done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= 9'd0;
      y_q        <= 9'd0;
      wd_q       <= 20'd0;
      job_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wd_q       <= wd_d;
      job_cnt_q  <= job_cnt_d;
      err_q      <= err_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
    end
  end

  assign start     = start_q;
  assign iX        = x_q;
  assign iY        = y_q;
  assign busy      = busy_q;
  assign all_done  = all_done_q;
  assign err       = err_q;
  assign job_cnt   = job_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_window_dispatcher.sv
// Bench for window_dispatcher: three grid configurations, an accelerator model with
// normal / silent / stale-done behaviour, and a scoreboard of expected origins and sweep ends.
module tb_window_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go_v   [3];
  logic        done_v [3];
  logic        start_v[3];
  logic [8:0]  ix_v   [3];
  logic [8:0]  iy_v   [3];
  logic        busy_v [3];
  logic        ad_v   [3];
  logic        err_v  [3];
  logic [15:0] jc_v   [3];
  logic [2:0]  st_v   [3];

  int sel  = 0;
  int mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_starts = 0;

  // Expected origin per start pulse {x, y}; expected sweep end {err, job_cnt, cycles since last start}.
  logic [17:0] exp_q[$];
  logic [24:0] exp_done_q[$];

  always #5 clk = ~clk;

  // dut0: basic grid (also watchdog and reset tests), dut1: strided, dut2: boundary
  window_dispatcher #(.XLAST(9'd2), .YLAST(9'd1), .STEP(9'd1), .TMO(20'd10)) dut0 (
    .clk(clk), .rst(rst), .go(go_v[0]), .done(done_v[0]), .start(start_v[0]),
    .iX(ix_v[0]), .iY(iy_v[0]), .busy(busy_v[0]), .all_done(ad_v[0]),
    .err(err_v[0]), .job_cnt(jc_v[0]), .dbg_state(st_v[0]));
  window_dispatcher #(.XLAST(9'd7), .YLAST(9'd7), .STEP(9'd4), .TMO(20'd10)) dut1 (
    .clk(clk), .rst(rst), .go(go_v[1]), .done(done_v[1]), .start(start_v[1]),
    .iX(ix_v[1]), .iY(iy_v[1]), .busy(busy_v[1]), .all_done(ad_v[1]),
    .err(err_v[1]), .job_cnt(jc_v[1]), .dbg_state(st_v[1]));
  window_dispatcher #(.XLAST(9'd511), .YLAST(9'd511), .STEP(9'd256), .TMO(20'd10)) dut2 (
    .clk(clk), .rst(rst), .go(go_v[2]), .done(done_v[2]), .start(start_v[2]),
    .iX(ix_v[2]), .iY(iy_v[2]), .busy(busy_v[2]), .all_done(ad_v[2]),
    .err(err_v[2]), .job_cnt(jc_v[2]), .dbg_state(st_v[2]));

  logic        m_start, m_busy, m_ad, m_err;
  logic [8:0]  m_ix, m_iy;
  logic [15:0] m_jc;
  logic [2:0]  m_st;

  always_comb begin
    m_start = start_v[sel];
    m_busy  = busy_v[sel];
    m_ad    = ad_v[sel];
    m_err   = err_v[sel];
    m_ix    = ix_v[sel];
    m_iy    = iy_v[sel];
    m_jc    = jc_v[sel];
    m_st    = st_v[sel];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accelerator model: cnt counts cycles since the last start pulse.
  // mode 0: done 3 cycles after start; 1: never; 2: also done in ISSUE, ADVANCE and FIN cycles.
  int cnt = 100;
  always @(posedge clk) begin
    logic d;
    #1;
    if (rst)             cnt = 100;
    else if (m_start)    cnt = 0;
    else if (cnt < 100)  cnt++;
    case (mode)
      0:       d = (cnt == 3);
      2:       d = (cnt <= 5) && (cnt != 1) && (cnt != 2);
      default: d = 1'b0;
    endcase
    for (int i = 0; i < 3; i++) done_v[i] = (i == sel) && d;
  end

  // Monitor: pops the scoreboard whenever the selected DUT pulses start or all_done.
  int cyc = 0;
  int last_start = 0;
  bit have_last = 1'b0;
  always @(negedge clk) begin
    logic [17:0] eo;
    logic [24:0] ed;
    logic [7:0]  gap;
    cyc++;
    gap = (cyc - last_start > 255) ? 8'hFF : 8'(cyc - last_start);
    if (rst) begin
      have_last = 1'b0;
    end else begin
      if (m_start) begin
        n_starts++;
        if (have_last) check("start_gap", 32'(gap), 32'd5);
        if (exp_q.size() == 0) begin
          check("unexpected_start", {14'd0, m_ix, m_iy}, 32'hFFFF_FFFF);
        end else begin
          eo = exp_q.pop_front();
          check("origin", {14'd0, m_ix, m_iy}, {14'd0, eo});
        end
        last_start = cyc;
        have_last  = 1'b1;
      end
      if (m_ad) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_all_done", {7'd0, m_err, m_jc, gap}, 32'hFFFF_FFFF);
        end else begin
          ed = exp_done_q.pop_front();
          check("sweep_end", {7'd0, m_err, m_jc, gap}, {7'd0, ed});
        end
        have_last = 1'b0;
      end
    end
  end

  task automatic push_org(input int x, input int y);
    exp_q.push_back({9'(x), 9'(y)});
  endtask

  task automatic push_basic();
    push_org(0, 0); push_org(1, 0); push_org(2, 0);
    push_org(0, 1); push_org(1, 1); push_org(2, 1);
  endtask

  // Raise go for one sample, check the start lands on the next cycle, wait for the sweep end.
  task automatic sweep(input int s, input int md);
    bit got;
    sel  = s;
    mode = md;
    @(negedge clk);
    go_v[s] = 1'b1;
    @(posedge clk);
    #1;
    check("go_to_start", {31'd0, m_start}, 32'd1);
    check("start_err_clear", {31'd0, m_err}, 32'd0);
    check("start_jc_zero", {16'd0, m_jc}, 32'd0);
    @(negedge clk);
    go_v[s] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (m_ad) got = 1'b1;
    end
    check("sweep_finished", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("busy_after_fin", {31'd0, m_busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_start",    {31'd0, start_v[i]}, 32'd0);
    check("rst_ix_iy",    {14'd0, ix_v[i], iy_v[i]}, 32'd0);
    check("rst_busy",     {31'd0, busy_v[i]}, 32'd0);
    check("rst_all_done", {31'd0, ad_v[i]}, 32'd0);
    check("rst_err",      {31'd0, err_v[i]}, 32'd0);
    check("rst_job_cnt",  {16'd0, jc_v[i]}, 32'd0);
    check("rst_state",    {29'd0, st_v[i]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      go_v[i]   = 1'b0;
      done_v[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    rst = 1'b0;
    @(negedge clk);

    // Basic sweep
    push_basic();
    exp_done_q.push_back({1'b0, 16'd6, 8'd5});
    sweep(0, 0);

    // Strided grid
    push_org(0, 0); push_org(4, 0); push_org(0, 4); push_org(4, 4);
    exp_done_q.push_back({1'b0, 16'd4, 8'd5});
    sweep(1, 0);

    // Boundary grid: 256 + 256 must not wrap back to 0
    push_org(0, 0); push_org(256, 0); push_org(0, 256); push_org(256, 256);
    exp_done_q.push_back({1'b0, 16'd4, 8'd5});
    sweep(2, 0);

    // Stale / early done: same origins and same 5-cycle job spacing
    push_basic();
    exp_done_q.push_back({1'b0, 16'd6, 8'd5});
    sweep(0, 2);

    // Watchdog: all_done 11 cycles after start (10 after WAIT entry), err sticky
    push_org(0, 0);
    exp_done_q.push_back({1'b1, 16'd0, 8'd11});
    sweep(0, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, m_err}, 32'd1);
    check("wd_job_cnt", {16'd0, m_jc}, 32'd0);

    // Next go clears err (checked inside sweep) and the sweep completes normally
    push_basic();
    exp_done_q.push_back({1'b0, 16'd6, 8'd5});
    sweep(0, 0);
    check("err_after_good_sweep", {31'd0, m_err}, 32'd0);

    // Reset mid-WAIT during job 3
    sel = 0;
    mode = 0;
    push_org(0, 0); push_org(1, 0); push_org(2, 0);
    n_starts = 0;
    @(negedge clk);
    go_v[0] = 1'b1;
    @(negedge clk);
    go_v[0] = 1'b0;
    for (int k = 0; k < 200 && n_starts < 3; k++) @(negedge clk);
    check("third_start_seen", 32'(n_starts), 32'd3);
    @(negedge clk);
    check("in_wait_before_rst", {29'd0, m_st}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    check("queue_after_rst", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    push_basic();
    exp_done_q.push_back({1'b0, 16'd6, 8'd5});
    sweep(0, 0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_done_q_drained", 32'(exp_done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_dispatcher.md
# window_dispatcher

Host-side job sequencer that drives the accelerator's `start`/`iX`/`iY` inputs and consumes its `done`. On `go`, it sweeps a raster grid of (x, y) window origins. For each origin it issues one `start` pulse, holds the coordinates stable, and waits for `done` before advancing. A watchdog aborts the sweep if the accelerator stalls.

## Interface
Parameters:
- `XLAST`, default 9'd63: last legal x origin (inclusive).
- `YLAST`, default 9'd63: last legal y origin (inclusive).
- `STEP`, default 9'd1: origin stride, identical for x and y; must be ≥1.
- `TMO`, default 20'd1000000: maximum cycles spent in WAIT per job.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: level-sampled in IDLE only; a sample of 1 begins a sweep.
- `done` in 1: accelerator completion; honoured only in WAIT.
- `start` out 1: one-cycle pulse to the accelerator.
- `iX` out 9: current x origin; stable from ISSUE through the end of WAIT.
- `iY` out 9: current y origin; same stability rule as `iX`.
- `busy` out 1: high in ISSUE, WAIT and ADVANCE.
- `all_done` out 1: one-cycle pulse when a sweep ends, whether it completes or aborts.
- `err` out 1: sticky watchdog flag; cleared when the next sweep starts.
- `job_cnt` out 16: number of jobs completed in the current or most recent sweep.

## Operation
- States: IDLE, ISSUE, WAIT, ADVANCE, FIN.
- IDLE:
  - `go`=1 → ISSUE.
  - On this transition: `iX`=0, `iY`=0, `job_cnt`=0, `err`=0.
- ISSUE:
  - `start`=1 for exactly this cycle.
  - Always → WAIT.
  - Watchdog counter cleared.
- WAIT:
  - Watchdog increments each cycle.
  - `done`=1 → ADVANCE.
  - Otherwise, if watchdog = TMO−1 → FIN with `err`=1.
  - If `done` and the timeout coincide, `done` wins.
- ADVANCE:
  - `job_cnt` += 1, saturating at 16'hFFFF.
  - Last-origin test: x+STEP > XLAST and y+STEP > YLAST.
    - If last → FIN; coordinates unchanged.
    - Otherwise → ISSUE with coordinates updated.
  - Coordinate update, x inner and y outer:
    - If x+STEP > XLAST: x=0 and y += STEP.
    - Otherwise: x += STEP.
- FIN:
  - `all_done`=1 for one cycle.
  - Always → IDLE.
- Arithmetic: the STEP sums are formed in 10 bits, so 511+STEP never wraps; the results truncate to 9 bits only after the compare.
- `done` sampled in IDLE, ISSUE, ADVANCE or FIN is ignored. This covers a stale `done` left over from the previous job.
- `go` is ignored outside IDLE. A `go` held high re-arms the sweep on the cycle after FIN returns to IDLE.
- `rst` in any state, including mid-WAIT:
  - Next state is IDLE.
  - All outputs return to their reset values.
  - The accelerator must be reset alongside.

## Timing
- Reset values: `start`=0, `iX`=0, `iY`=0, `busy`=0, `all_done`=0, `err`=0, `job_cnt`=0; state IDLE.
- `go` sampled at edge n → `start`=1 during cycle n+1.
- `done` sampled high at edge m → ADVANCE in cycle m+1 → next `start` in cycle m+2.
  - Job-to-job overhead is 2 cycles plus the accelerator latency.
- Last job: `done` at edge m → `all_done` high in cycle m+2 → `busy`=0 and IDLE from cycle m+3.
- Coordinates change only on the ADVANCE→ISSUE edge, never while `start` is high or during WAIT.
- Total jobs per sweep: (⌊XLAST/STEP⌋+1)·(⌊YLAST/STEP⌋+1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic sweep:
  - Setup: XLAST=2, YLAST=1, STEP=1; accelerator model raises `done` 3 cycles after `start`.
  - Required: exactly 6 `start` pulses with origins (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - Required: `job_cnt`=6, one `all_done` pulse, `err`=0.
- Strided grid:
  - Setup: XLAST=7, YLAST=7, STEP=4.
  - Required: origins (0,0),(4,0),(0,4),(4,4).
  - Required: `job_cnt`=4; no origin exceeds 7.
- Boundary grid:
  - Setup: XLAST=YLAST=511, STEP=256.
  - Required: origins (0,0),(256,0),(0,256),(256,256), then `all_done`; no 9-bit wrap to 0.
- Stale and early `done`:
  - Stimulus: hold `done`=1 during ISSUE and ADVANCE.
  - Required: no extra advances; each job still waits for a `done` sampled in WAIT.
  - Stimulus: assert `done` in the same cycle as `start`.
  - Required: it is ignored.
- Watchdog:
  - Setup: TMO=10; model never asserts `done`.
  - Required: `all_done` 10 cycles after WAIT entry; `err`=1 and stays 1; `job_cnt`=0.
  - Stimulus: next `go`.
  - Required: `err` clears.
- Reset mid-WAIT during job 3 of the basic sweep:
  - Required: next cycle all outputs are at their reset values.
  - Required: a subsequent `go` restarts at (0,0) with `job_cnt`=0.
